// File: rtl/seq_pattern_det_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_det_if
//  Purpose  : Bundles the serial data, configuration and match-result signals
//             of the programmable bit-pattern detector.
//  Signals  : x, x_valid              serial bit and its qualifier
//             cfg_load/pat/len/ovl    runtime pattern configuration
//             cnt_clr                 synchronous match-counter clear
//             y, y_q, match_cnt       combinational / registered match, count
//  Modports : master (stream source / consumer), slave (detector)
//  Revision : 1.0  initial release
// ============================================================================
interface seq_pattern_det_if #(
    parameter int PAT_W = 4,
    parameter int LEN_W = 3,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             cnt_clr;
    logic             y;
    logic             y_q;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, x_valid, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        input  y, y_q, match_cnt
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        output y, y_q, match_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_det.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_det
//  Purpose  : Programmable serial bit-pattern detector. Flags every occurrence
//             of a runtime-loaded pattern of 1..PAT_W bits (overlapping or
//             non-overlapping) and keeps a saturating match count.
//  Ports    : CLK   clock, rising edge
//             RST   asynchronous active-high reset
//             bus   seq_pattern_det_if.slave (stream, config, match outputs)
//  Revision : 1.0  initial release
// ============================================================================
module seq_pattern_det #(
    parameter int             PAT_W   = 4,
    parameter int             LEN_W   = 3,
    parameter int             CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1101,
    parameter int             DEF_LEN = 4,
    parameter logic           DEF_OVL = 1'b1
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    seq_pattern_det_if.slave   bus
);

    localparam int                c_FILL_W   = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0]  c_PAT_LEN  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0]  c_DEF_LEN  = (DEF_LEN < 1 || DEF_LEN > PAT_W) ?
                                               c_PAT_LEN : LEN_W'(DEF_LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

    // Only the newest PAT_W-1 past samples are ever needed: together with the
    // live bit they form the full PAT_W-bit comparison window.
    logic [PAT_W-2:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]    r_pat;
    logic [LEN_W-1:0]    r_len;
    logic                r_ovl;
    logic                r_y_q;
    logic [CNT_W-1:0]    r_cnt;

    logic [PAT_W-1:0]    w_win;
    logic [PAT_W-1:0]    w_mask;
    logic                w_fill_ok;
    logic                w_hit;
    logic                w_y;
    logic [LEN_W-1:0]    w_cfg_len;

    assign w_win = {r_hist, bus.x};

    // Thermometer mask selecting the active low len bits of the window.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_fill_ok = (32'(r_fill) + 32'd1) >= 32'(r_len);
    assign w_hit     = ((w_win ^ r_pat) & w_mask) == '0;
    assign w_y       = bus.x_valid & ~bus.cfg_load & w_fill_ok & w_hit;

    // Out-of-range lengths (0 or beyond PAT_W) fall back to the full width.
    assign w_cfg_len = ((bus.cfg_len == '0) || (32'(bus.cfg_len) > 32'(PAT_W))) ?
                       c_PAT_LEN : bus.cfg_len;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEF_PAT;
            r_len  <= c_DEF_LEN;
            r_ovl  <= DEF_OVL;
            r_y_q  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_y_q <= w_y;

            if (bus.cfg_load) begin
                // New configuration discards any partial sequence.
                r_pat  <= bus.cfg_pat;
                r_len  <= w_cfg_len;
                r_ovl  <= bus.cfg_ovl;
                r_hist <= '0;
                r_fill <= '0;
            end else if (bus.x_valid) begin
                r_hist <= w_win[PAT_W-2:0];
                if (w_y && !r_ovl) begin
                    r_fill <= '0;
                end else if (r_fill != c_FILL_MAX) begin
                    r_fill <= r_fill + c_FILL_W'(1);
                end
            end

            // Clear takes priority over a simultaneous match.
            if (bus.cnt_clr) begin
                r_cnt <= '0;
            end else if (w_y && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.y         = w_y;
    assign bus.y_q       = r_y_q;
    assign bus.match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/seq_pattern_det.md
# seq_pattern_det

Parametrised serial bit-pattern detector: a programmable, variable-length successor to the fixed 1101 detector. It samples a qualified serial bit stream and flags every occurrence of a runtime-loaded pattern of 1..PAT_W bits, in overlapping or non-overlapping mode. It keeps a saturating match count. It sits directly on a serial receive path, after bit recovery, and feeds framing or sync logic.

## Interface
- PAT_W, 4, maximum pattern length in bits (2..32)
- LEN_W, 3, width of the length field; must hold PAT_W
- CNT_W, 8, match counter width
- DEF_PAT, 4'b1101, pattern loaded at reset (PAT_W bits)
- DEF_LEN, 4, pattern length loaded at reset
- DEF_OVL, 1, overlap mode loaded at reset
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- x  in  1  serial data bit
- x_valid  in  1  x is sampled this cycle
- cfg_load  in  1  load cfg_pat, cfg_len and cfg_ovl at this edge
- cfg_pat  in  PAT_W  pattern; active bits are [len-1:0], and bit [len-1] is received first
- cfg_len  in  LEN_W  pattern length
- cfg_ovl  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of match_cnt
- y  out  1  Mealy match; combinational, high in the cycle the final pattern bit is presented
- y_q  out  1  y registered (one cycle later)
- match_cnt  out  CNT_W  saturating count of matches

## Operation
- State:
  - hist: PAT_W-bit shift register of past samples, newest in bit 0
  - fill: 0..PAT_W, the number of valid samples in hist
  - pat, len, ovl: the active configuration
- Reset: hist=0, fill=0, pat=DEF_PAT, len=DEF_LEN, ovl=DEF_OVL, y_q=0, match_cnt=0. y is therefore 0 during and immediately after reset.
- Window: win = {hist[PAT_W-2:0], x}.
- y = x_valid & !cfg_load & (fill+1 >= len) & (win[len-1:0] == pat[len-1:0]).
- On an x_valid edge without cfg_load:
  - hist <= win.
  - If y and ovl=0: fill <= 0.
  - Otherwise: fill <= min(fill+1, PAT_W).
- When x_valid=0, hist and fill hold and y=0. Gaps in x_valid do not break a sequence.
- cfg_load:
  - pat <= cfg_pat, len <= cfg_len, ovl <= cfg_ovl, hist <= 0, fill <= 0.
  - A cfg_len of 0 or greater than PAT_W loads PAT_W.
  - cfg_load has priority over x_valid: the sample in that cycle is discarded, y is forced to 0, and match_cnt does not increment.
  - match_cnt is not affected by cfg_load.
- match_cnt:
  - Increments on each edge where y=1.
  - Saturates at 2^CNT_W-1.
  - When cnt_clr=1 it becomes 0, including when y=1 in the same cycle (clear wins).
- y_q <= y on every edge.
- len=1: every valid bit equal to pat[0] matches. In that case ovl has no effect on the output sequence.

## Timing
- Latency:
  - y is asserted in the same cycle as the final pattern bit, combinationally from x.
  - y_q is asserted one edge later.
  - match_cnt reflects the match after that same edge.
- Configuration applies to samples from the cycle after cfg_load. The first possible match is len valid samples after the load edge.
- Asserting RST mid-stream:
  - Immediately clears y_q and match_cnt.
  - Restores the DEF_* configuration and discards any partial sequence.
  - y drops as soon as the reset clears fill.
- The combinational path from x/x_valid to y is a comparator of depth PAT_W. Registered consumers should use y_q.

## Test plan
- Defaults, overlap on, x=1,1,0,1,1,0,1 with x_valid=1 -> y high on the 4th and 7th samples. match_cnt=2 and y_q pulses one cycle after each.
- Load pat=1101, len=4, ovl=0, same stream -> y high only on the 4th sample; match_cnt=1.
- Load pat=4'b0101, len=3 (active 101), ovl=1, stream 1,0,1,0,1 -> matches on the 3rd and 5th samples. Also drive x_valid=0 for 3 cycles between the 2nd and 3rd samples -> the 3rd-sample match still occurs.
- cfg_load in the same cycle as the final bit of a match -> y=0, no increment, hist cleared. Also cfg_len=0 -> len reads back as PAT_W via a full-length match.
- CNT_W=2, 5 matches -> match_cnt stops at 3. cnt_clr in the same cycle as a match -> match_cnt=0.
- Assert RST asynchronously after 3 of 4 pattern bits -> y_q=0 and match_cnt=0 immediately. After release, sending only the 4th bit produces no match.
